// File: rtl/dev_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dev_bus_arbiter
// Brief    : Two-master round-robin arbiter/sequencer for the device bus pair
//            (dev0 at 0x7F00-0x7F0F, dev1 at 0x7F10-0x7F1F) with wait cycles.
// Revision : 1.0 - initial release
// ============================================================================
module dev_bus_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [29:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic [31:0] m0_rd,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [29:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic [31:0] m1_rd,
    output logic        m1_ack,
    output logic [29:0] DevAddr,
    output logic [31:0] DevWD,
    output logic        We0,
    output logic        We1,
    input  logic [31:0] readdev0,
    input  logic [31:0] readdev1,
    output logic        busy,
    output logic        gnt
);

    localparam logic [3:0]  c_last      = 4'(WAIT_CYCLES - 1);
    localparam logic [27:0] c_dev0_base = 28'h00007F0;
    localparam logic [27:0] c_dev1_base = 28'h00007F1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_gnt;
    logic        r_we;
    logic [29:0] r_addr;
    logic [31:0] r_wd;
    logic [31:0] r_m0_rd;
    logic [31:0] r_m1_rd;

    logic        w_any_req;
    logic        w_grant;
    logic        w_hit0;
    logic        w_hit1;
    logic        w_last;
    logic        w_access;
    logic        w_done;
    logic [31:0] w_rdata;

    // Word address bits [29:2] are byte address bits [31:4].
    assign w_hit0    = (r_addr[29:2] == c_dev0_base);
    assign w_hit1    = (r_addr[29:2] == c_dev1_base);
    assign w_last    = (r_cnt == c_last);
    assign w_any_req = m0_req | m1_req;
    assign w_rdata   = w_hit0 ? readdev0 : (w_hit1 ? readdev1 : 32'h0);

    always_comb begin
        w_grant     = 1'b0;
        w_state_nxt = r_state;
        // Contention goes to whichever master was not served last.
        if (m0_req && m1_req) begin
            w_grant = ~r_gnt;
        end else if (m1_req) begin
            w_grant = 1'b1;
        end
        case (r_state)
            S_IDLE:   if (w_any_req) w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_last)    w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_gnt   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= 30'h0;
            r_wd    <= 32'h0;
            r_m0_rd <= 32'h0;
            r_m1_rd <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt  <= w_grant;
                        r_cnt  <= 4'd0;
                        r_we   <= w_grant ? m1_we   : m0_we;
                        r_addr <= w_grant ? m1_addr : m0_addr;
                        r_wd   <= w_grant ? m1_wd   : m0_wd;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) begin
                        if (r_gnt) begin
                            r_m1_rd <= w_rdata;
                        end else begin
                            r_m0_rd <= w_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Reset gates the bus outputs so an aborted access never strobes or acks.
    assign w_access = (r_state == S_ACCESS) && !reset;
    assign w_done   = (r_state == S_DONE) && !reset;

    assign DevAddr = w_access ? r_addr : 30'h0;
    assign DevWD   = w_access ? r_wd   : 32'h0;
    assign We0     = w_access && r_we && w_hit0 && (r_cnt == 4'd0);
    assign We1     = w_access && r_we && w_hit1 && (r_cnt == 4'd0);

    assign m0_ack = w_done && !r_gnt;
    assign m1_ack = w_done && r_gnt;
    assign m0_rd  = r_m0_rd;
    assign m1_rd  = r_m1_rd;
    assign busy   = (r_state != S_IDLE);
    assign gnt    = r_gnt;

endmodule
`default_nettype wire
